// File: rtl/regfile_writeback_arbiter_if.sv
// Bus between the execute/memory stages and the register-file write-back arbiter.
// The master side produces results. The slave side is the arbiter.
interface regfile_writeback_arbiter_if #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 4
);
   localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

   // Single-cycle ALU result path. It has no back-pressure.
   logic                     alu_valid;
   logic [ADDRESS_WIDTH-1:0] alu_rd;
   logic [DATA_WIDTH-1:0]    alu_data;
   logic                     alu_hold;

   // Long-latency result path, which uses a valid/ready handshake.
   logic                     mem_valid;
   logic                     mem_ready;
   logic [ADDRESS_WIDTH-1:0] mem_rd;
   logic [DATA_WIDTH-1:0]    mem_data;

   // Register file write port and status outputs.
   logic                     reg_write;
   logic [ADDRESS_WIDTH-1:0] reg_waddr;
   logic [DATA_WIDTH-1:0]    reg_wdata;
   logic [COUNT_WIDTH-1:0]   fifo_count;
   logic                     proto_err;

   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
      input  alu_hold, mem_ready, reg_write, reg_waddr, reg_wdata, fifo_count, proto_err
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
      output alu_hold, mem_ready, reg_write, reg_waddr, reg_wdata, fifo_count, proto_err
   );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Write-back arbiter for the single register-file write port.
// ALU results always win arbitration. Long-latency results queue in an in-order FIFO.
// A starvation counter raises alu_hold so that the FIFO head is eventually written.
module regfile_writeback_arbiter #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int STARVE_LIMIT  = 8
) (
   input logic                         clock,
   input logic                         reset,
   regfile_writeback_arbiter_if.slave  bus_io
);
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   // FIFO storage and pointers. Occupancy tells a full FIFO apart from an empty one.
   logic [ADDRESS_WIDTH-1:0] rd_mem   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]    data_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]         count_q,  count_d;

   logic [STARVE_W-1:0]      starve_q, starve_d;
   logic                     alu_hold_q, alu_hold_d;
   logic                     proto_err_q, proto_err_d;

   logic                     reg_write_q, reg_write_d;
   logic [ADDRESS_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
   logic [DATA_WIDTH-1:0]    reg_wdata_q, reg_wdata_d;

   logic alu_req, fifo_req, mem_ready, push, pop;

   // Request decode. Writes to x0 are discarded at the door.
   assign alu_req   = bus_io.alu_valid && (bus_io.alu_rd != '0);
   assign fifo_req  = (count_q != '0);
   assign mem_ready = (count_q != CNT_W'(FIFO_DEPTH));
   assign push      = bus_io.mem_valid && mem_ready && (bus_io.mem_rd != '0);
   assign pop       = !alu_req && fifo_req;

   // Next-state computation for the FIFO bookkeeping, arbitration, and starvation control.
   always_comb begin
      // NOTE: every always_comb target gets a default first so no latch can be inferred.
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      reg_write_d = 1'b0;
      reg_waddr_d = reg_waddr_q;
      reg_wdata_d = reg_wdata_q;
      starve_d    = starve_q;
      alu_hold_d  = alu_hold_q;
      proto_err_d = proto_err_q || (bus_io.alu_valid && alu_hold_q);

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      if (alu_req) begin
         reg_write_d = 1'b1;
         reg_waddr_d = bus_io.alu_rd;
         reg_wdata_d = bus_io.alu_data;
      end else if (pop) begin
         reg_write_d = 1'b1;
         reg_waddr_d = rd_mem[rd_ptr_q];
         reg_wdata_d = data_mem[rd_ptr_q];
         rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      end

      // The counter measures how long the current head has been losing to the ALU.
      if (pop || !fifo_req) begin
         starve_d = '0;
      end else if (alu_req && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
         starve_d = starve_q + STARVE_W'(1);
      end

      if (pop) begin
         alu_hold_d = 1'b0;
      end else if (starve_d == STARVE_W'(STARVE_LIMIT)) begin
         alu_hold_d = 1'b1;
      end
   end

   // Control state register. Reset discards any queued entries.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         starve_q    <= '0;
         alu_hold_q  <= 1'b0;
         proto_err_q <= 1'b0;
         reg_write_q <= 1'b0;
         reg_waddr_q <= '0;
         reg_wdata_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         starve_q    <= starve_d;
         alu_hold_q  <= alu_hold_d;
         proto_err_q <= proto_err_d;
         reg_write_q <= reg_write_d;
         reg_waddr_q <= reg_waddr_d;
         reg_wdata_q <= reg_wdata_d;
      end
   end

   // FIFO payload write on an accepted non-x0 push.
   always_ff @(posedge clock) begin
      // NOTE: the payload array has no reset. Occupancy alone decides which entries are valid.
      if (push) begin
         rd_mem[wr_ptr_q]   <= bus_io.mem_rd;
         data_mem[wr_ptr_q] <= bus_io.mem_data;
      end
   end

   assign bus_io.mem_ready  = mem_ready;
   assign bus_io.fifo_count = count_q;
   assign bus_io.alu_hold   = alu_hold_q;
   assign bus_io.proto_err  = proto_err_q;
   assign bus_io.reg_write  = reg_write_q;
   assign bus_io.reg_waddr  = reg_waddr_q;
   assign bus_io.reg_wdata  = reg_wdata_q;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter. Directed scenarios are followed by random traffic.
// Every edge is compared against a queue-based reference model.
module tb_regfile_writeback_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic clock;
   logic reset;

   regfile_writeback_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

   regfile_writeback_arbiter #(
      .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .bus_io (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model: a queue of pending results plus plain integer bookkeeping.
   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } entry_t;

   entry_t        q[$];
   int            starve;
   bit            m_hold, m_perr, m_write;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      starve  = 0;
      m_hold  = 0;
      m_perr  = 0;
      m_write = 0;
      m_waddr = '0;
      m_wdata = '0;
   endtask

   // Applies the arbitration rules to the inputs currently on the bus, for the coming edge.
   task automatic model_step();
      int     pre;
      bit     alu_req, pop, push;
      entry_t e;
      pre     = q.size();
      alu_req = bus.alu_valid && (bus.alu_rd != 0);
      pop     = !alu_req && (pre > 0);
      push    = bus.mem_valid && (pre != DEPTH) && (bus.mem_rd != 0);
      if (bus.alu_valid && m_hold) m_perr = 1;
      if (alu_req) begin
         m_write = 1; m_waddr = bus.alu_rd; m_wdata = bus.alu_data;
      end else if (pop) begin
         e = q.pop_front();
         m_write = 1; m_waddr = e.rd; m_wdata = e.data;
      end else begin
         m_write = 0;
      end
      if (push) begin
         e.rd = bus.mem_rd; e.data = bus.mem_data;
         q.push_back(e);
      end
      if (pop || pre == 0) starve = 0;
      else if (alu_req && starve < LIMIT) starve++;
      if (pop) m_hold = 0;
      else if (starve == LIMIT) m_hold = 1;
   endtask

   task automatic compare_all();
      check("reg_write",  64'(bus.reg_write),  64'(m_write));
      check("reg_waddr",  64'(bus.reg_waddr),  64'(m_waddr));
      check("reg_wdata",  64'(bus.reg_wdata),  64'(m_wdata));
      check("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
      check("mem_ready",  64'(bus.mem_ready),  64'(q.size() != DEPTH));
      check("alu_hold",   64'(bus.alu_hold),   64'(m_hold));
      check("proto_err",  64'(bus.proto_err),  64'(m_perr));
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      compare_all();
   endtask

   task automatic drive(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] adata,
                        input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mdata);
      bus.alu_valid = av;
      bus.alu_rd    = ard;
      bus.alu_data  = adata;
      bus.mem_valid = mv;
      bus.mem_rd    = mrd;
      bus.mem_data  = mdata;
   endtask

   // Asserts reset between edges, checks the cleared state, then releases reset.
   task automatic pulse_reset();
      #2 reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      #1;
      model_reset();
      check("rst_reg_write",  64'(bus.reg_write),  64'd0);
      check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
      check("rst_mem_ready",  64'(bus.mem_ready),  64'd1);
      check("rst_alu_hold",   64'(bus.alu_hold),   64'd0);
      check("rst_proto_err",  64'(bus.proto_err),  64'd0);
      #1 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      #3;
      check("por_reg_write", 64'(bus.reg_write), 64'd0);
      check("por_reg_waddr", 64'(bus.reg_waddr), 64'd0);
      check("por_reg_wdata", 64'(bus.reg_wdata), 64'd0);
      check("por_mem_ready", 64'(bus.mem_ready), 64'd1);
      #9 reset = 1'b0;
      tick();

      // Queue three entries behind a busy ALU, then reset while they are still pending.
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 32'h11, 1, AW'(3 + i), DW'(32'hC0 + i));
         tick();
      end
      check("pend_count", 64'(bus.fifo_count), 64'd3);
      pulse_reset();
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_no_write", 64'(bus.reg_write), 64'd0);
      end

      // ALU only: the result is visible one cycle later. An x0 destination produces no write.
      drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
      tick();
      check("alu_write", 64'(bus.reg_write), 64'd1);
      check("alu_waddr", 64'(bus.reg_waddr), 64'd5);
      check("alu_wdata", 64'(bus.reg_wdata), 64'hDEADBEEF);
      drive(1, 0, 32'h12345678, 0, 0, 0);
      tick();
      check("alu_x0_write", 64'(bus.reg_write), 64'd0);
      check("alu_x0_hold_addr", 64'(bus.reg_waddr), 64'd5);

      // Fill the FIFO behind a busy ALU. A fifth offer must be refused.
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, DW'(i), 1, AW'(10 + i), DW'(32'hA0 + i));
         tick();
      end
      check("full_ready", 64'(bus.mem_ready), 64'd0);
      drive(1, 1, 32'h5, 1, 14, 32'hA4);
      tick();
      check("full_held_count", 64'(bus.fifo_count), 64'd4);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("drain_write", 64'(bus.reg_write), 64'd1);
         check("drain_waddr", 64'(bus.reg_waddr), 64'(10 + i));
         check("drain_wdata", 64'(bus.reg_wdata), 64'(32'hA0 + i));
      end
      check("drain_ready", 64'(bus.mem_ready), 64'd1);

      // Push and pop in the same cycle at occupancy 2. Then push an x0 entry.
      drive(1, 2, 32'h77, 1, 20, 32'hB0); tick();
      drive(1, 2, 32'h78, 1, 21, 32'hB1); tick();
      drive(0, 0, 0, 1, 22, 32'hB2);
      tick();
      check("pp_count", 64'(bus.fifo_count), 64'd2);
      check("pp_waddr", 64'(bus.reg_waddr), 64'd20);
      drive(1, 3, 32'h99, 1, 0, 32'hBAD);
      tick();
      check("x0_push_count", 64'(bus.fifo_count), 64'd2);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick();
      check("x0_never_written", 64'(bus.reg_write), 64'd0);

      // Starvation: one queued entry that loses to the ALU on every cycle.
      drive(1, 1, 32'h1, 1, 7, 32'hE7);
      tick();
      drive(1, 1, 32'h1, 0, 0, 0);
      for (int i = 1; i <= LIMIT; i++) begin
         tick();
         check("starve_hold", 64'(bus.alu_hold), 64'(i == LIMIT));
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      check("starve_pop_waddr", 64'(bus.reg_waddr), 64'd7);
      check("starve_hold_clear", 64'(bus.alu_hold), 64'd0);

      // Protocol violation: the ALU is sent while hold is raised.
      drive(1, 1, 32'h1, 1, 8, 32'hE8);
      tick();
      drive(1, 1, 32'h1, 0, 0, 0);
      for (int i = 0; i < LIMIT; i++) tick();
      check("pv_hold", 64'(bus.alu_hold), 64'd1);
      drive(1, 9, 32'hFACE, 0, 0, 0);
      tick();
      check("pv_alu_wins", 64'(bus.reg_waddr), 64'd9);
      check("pv_proto_err", 64'(bus.proto_err), 64'd1);
      check("pv_hold_kept", 64'(bus.alu_hold), 64'd1);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick();
      check("pv_sticky", 64'(bus.proto_err), 64'd1);

      // Random traffic. Upstream mostly honours alu_hold.
      for (int i = 0; i < 400; i++) begin
         drive(bus.alu_hold ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1),
               AW'($urandom_range(0, 31)), DW'($urandom()),
               $urandom_range(0, 2) != 0, AW'($urandom_range(0, 31)), DW'($urandom()));
         tick();
      end

      pulse_reset();
      tick();
      check("final_proto_clear", 64'(bus.proto_err), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
